// File: rtl/counter_display_driver_if.sv
// Value-in / display-out bundle for counter_display_driver.
interface counter_display_driver_if #(
    parameter int N = 8
);
    logic [N-1:0] value;
    logic [6:0]   segments;
    logic [3:0]   anodes;
    logic         dp;
    logic         busy;

    modport master (output value, input segments, input anodes, input dp, input busy);
    modport slave  (input value, output segments, output anodes, output dp, output busy);
endinterface

// File: rtl/counter_display_driver.sv
// Binary-to-BCD (shift/add-3) converter feeding a 4-digit multiplexed 7-segment display.
//   state | meaning
//   IDLE  | sample value, clear BCD scratch and shift count
//   SHIFT | N add-3/shift steps
//   LATCH | copy finished BCD into the digit register
module counter_display_driver #(
    parameter int N           = 8,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                      clock,
    input  logic                      reset,
    counter_display_driver_if.slave   bus
);
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   bin_q, bin_d;
    logic [15:0]    bcd_q, bcd_d, bcd_adj;
    logic [3:0]     cnt_q, cnt_d;
    logic [15:0]    digits_q, digits_d;
    logic           busy_q, busy_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [1:0]     sel_q, sel_d;
    logic           presc_tc;

    function automatic logic [15:0] bcd_adjust(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    always_comb begin
        state_d  = state_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        digits_d = digits_q;
        bcd_adj  = bcd_adjust(bcd_q);
        case (state_q)
            IDLE: begin
                bin_d   = bus.value;
                bcd_d   = '0;
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                bcd_d = {bcd_adj[14:0], bin_q[N-1]};
                bin_d = bin_q << 1;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(N - 1)) state_d = LATCH;
            end
            LATCH: begin
                digits_d = bcd_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // busy is registered, so it follows the state being entered
        busy_d = (state_d != IDLE);
    end

    always_comb begin
        presc_tc = (presc_q == PW'(REFRESH_DIV - 1));
        presc_d  = presc_tc ? '0 : presc_q + PW'(1);
        sel_d    = presc_tc ? sel_q + 2'd1 : sel_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            digits_q <= '0;
            busy_q   <= 1'b0;
            presc_q  <= '0;
            sel_q    <= '0;
        end else begin
            state_q  <= state_d;
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
            busy_q   <= busy_d;
            presc_q  <= presc_d;
            sel_q    <= sel_d;
        end
    end

    logic [3:0] digit;
    logic       blank;
    logic [6:0] seg;

    // A digit is blanked when it and every digit above it are zero; units never blank.
    always_comb begin
        digit = digits_q[3:0];
        blank = 1'b0;
        case (sel_q)
            2'd0: begin digit = digits_q[3:0];   blank = 1'b0;                    end
            2'd1: begin digit = digits_q[7:4];   blank = (digits_q[15:4] == '0);  end
            2'd2: begin digit = digits_q[11:8];  blank = (digits_q[15:8] == '0);  end
            2'd3: begin digit = digits_q[15:12]; blank = (digits_q[15:12] == '0); end
            default: begin digit = digits_q[3:0]; blank = 1'b0; end
        endcase
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
        if (blank) seg = 7'b1111111;
    end

    assign bus.segments = seg;
    assign bus.anodes   = ~(4'b0001 << sel_q);
    assign bus.dp       = 1'b1;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_counter_display_driver.sv
// Directed bench for counter_display_driver at N=8, REFRESH_DIV=4.
module tb_counter_display_driver;
    logic clock;
    logic reset;
    int   vecs  = 0;
    int   fails = 0;
    int   k     = 0;   // rising edges since reset was last released

    counter_display_driver_if #(.N(8)) bus ();

    counter_display_driver #(.N(8), .REFRESH_DIV(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        k++;
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s (k=%0d): observed %b, expected %b", tag, k, obs, exp);
        end
    endtask

    // Select advances on every 4th edge after release, so it is (k/4)%4.
    task automatic chk_disp(input string tag, input logic [6:0] t0, input logic [6:0] t1,
                            input logic [6:0] t2, input logic [6:0] t3);
        int s;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        s = (k / 4) % 4;
        case (s)
            0: begin exp_an = 4'b1110; exp_seg = t0; end
            1: begin exp_an = 4'b1101; exp_seg = t1; end
            2: begin exp_an = 4'b1011; exp_seg = t2; end
            default: begin exp_an = 4'b0111; exp_seg = t3; end
        endcase
        chk({tag, "_anodes"}, {3'b000, bus.anodes}, {3'b000, exp_an});
        chk({tag, "_seg"}, bus.segments, exp_seg);
    endtask

    localparam logic [6:0] BL = 7'b1111111;

    initial begin
        reset     = 1'b1;
        bus.value = '0;
        @(negedge clock);
        tick();
        tick();
        chk("rst_anodes", {3'b000, bus.anodes}, 7'b0001110);
        chk("rst_seg", bus.segments, 7'b1000000);
        chk("rst_dp", {6'b0, bus.dp}, 7'd1);
        chk("rst_busy", {6'b0, bus.busy}, 7'd0);

        // 255: sampled on edge 1, digit register updates on edge 10
        reset     = 1'b0;
        bus.value = 8'd255;
        k         = 0;
        tick();
        chk("busy_shift", {6'b0, bus.busy}, 7'd1);
        while (k < 9) tick();
        chk("busy_latch", {6'b0, bus.busy}, 7'd1);
        chk_disp("pre255", 7'b1000000, 7'b1000000, BL, BL);
        tick();
        chk("busy_idle", {6'b0, bus.busy}, 7'd0);
        chk_disp("first255", 7'b0010010, 7'b0010010, 7'b0100100, BL);
        while (k < 26) begin
            tick();
            chk_disp("scan255", 7'b0010010, 7'b0010010, 7'b0100100, BL);
        end
        chk("dp_off", {6'b0, bus.dp}, 7'd1);

        // 7: sampled on edge 31, shown from edge 40
        bus.value = 8'd7;
        while (k < 39) tick();
        chk_disp("hold255", 7'b0010010, 7'b0010010, 7'b0100100, BL);
        while (k < 55) begin
            tick();
            chk_disp("show7", 7'b1111000, BL, BL, BL);
        end

        // 100 sampled on edge 61, changed to 42 mid-conversion; 42 sampled on edge 71
        bus.value = 8'd100;
        while (k < 95) begin
            if (k == 63) bus.value = 8'd42;
            tick();
            if (k < 70)
                chk_disp("still7", 7'b1111000, BL, BL, BL);
            else if (k < 80)
                chk_disp("show100", 7'b1000000, 7'b1000000, 7'b1111001, BL);
            else
                chk_disp("show42", 7'b0100100, 7'b0011001, BL, BL);
        end

        // 200 sampled on edge 101; reset lands on the 4th SHIFT cycle (edge 105)
        bus.value = 8'd200;
        while (k < 104) tick();
        chk("busy_mid", {6'b0, bus.busy}, 7'd1);
        reset = 1'b1;
        tick();
        chk("abort_busy", {6'b0, bus.busy}, 7'd0);
        chk("abort_anodes", {3'b000, bus.anodes}, 7'b0001110);
        chk("abort_seg", bus.segments, 7'b1000000);
        reset = 1'b0;
        k     = 0;
        tick();
        chk("resample_busy", {6'b0, bus.busy}, 7'd1);
        while (k < 9) tick();
        chk_disp("pre200", 7'b1000000, 7'b1000000, BL, BL);
        tick();
        chk_disp("first200", 7'b1000000, 7'b1000000, 7'b0100100, BL);
        while (k < 26) begin
            tick();
            chk_disp("scan200", 7'b1000000, 7'b1000000, 7'b0100100, BL);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule
